regfile_mp: RTL

Parametrised multi-port integer register file for the RISC-V core. It succeeds the single-write, dual-read register file with configurable width, depth, read-port and write-port counts, and a per-register pending-write scoreboard. Same-cycle write-to-read bypass is prioritised across write ports. It sits between decode/issue, which reads operands and marks destinations busy, and writeback, which writes results and clears busy bits.

---
 rtl/regfile_pkg.sv | 16 +
 rtl/regfile_scoreboard.sv | 66 ++++++
 rtl/regfile_mp.sv | 85 ++++++++
 3 files changed

// File: rtl/regfile_pkg.sv
`default_nettype none
// ============================================================================
// regfile_pkg : shared defaults and types for the multi-port register file
// Rev 1.0
// ============================================================================
package regfile_pkg;

    localparam int XLEN_DEF  = 64;
    localparam int NREGS_DEF = 32;
    localparam int AW_DEF    = $clog2(NREGS_DEF);

    typedef logic [AW_DEF-1:0]   reg_addr_t;
    typedef logic [XLEN_DEF-1:0] xlen_t;

endpackage
`default_nettype wire

// File: rtl/regfile_scoreboard.sv
`default_nettype none
// ============================================================================
// regfile_scoreboard : per-register pending-write busy bits and rd_busy lookup
// Rev 1.0
// ============================================================================
module regfile_scoreboard
    import regfile_pkg::*;
#(
    parameter  int NREGS = NREGS_DEF,
    parameter  int NRD   = 2,
    parameter  int NWR   = 2,
    localparam int AW    = $clog2(NREGS)
) (
    input  logic              clk,
    input  logic              reset,
    input  logic [NRD*AW-1:0] rd_addr,
    output logic [NRD-1:0]    rd_busy,
    input  logic [NWR-1:0]    wr_en,
    input  logic [NWR*AW-1:0] wr_addr,
    input  logic              iss_en,
    input  logic [AW-1:0]     iss_addr,
    input  logic              flush
);

    logic [NREGS-1:0] r_busy;
    logic [NREGS-1:0] w_busy_nxt;
    logic [NREGS-1:0] w_clr;

    always_comb begin
        w_clr = '0;
        for (int j = 0; j < NWR; j++) begin
            if (wr_en[j]) begin
                w_clr[wr_addr[j*AW +: AW]] = 1'b1;
            end
        end
    end

    // Later statements override earlier ones: flush beats issue beats clear.
    always_comb begin
        w_busy_nxt = r_busy & ~w_clr;
        if (iss_en) begin
            w_busy_nxt[iss_addr] = 1'b1;
        end
        if (flush) begin
            w_busy_nxt = '0;
        end
        w_busy_nxt[0] = 1'b0;
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_busy <= '0;
        end else begin
            r_busy <= w_busy_nxt;
        end
    end

    // A result arriving this cycle is bypassed, so the operand counts as ready.
    for (genvar i = 0; i < NRD; i++) begin : g_rd_busy
        logic [AW-1:0] w_addr;
        assign w_addr     = rd_addr[i*AW +: AW];
        assign rd_busy[i] = (w_addr != '0) && r_busy[w_addr] && !w_clr[w_addr];
    end

endmodule
`default_nettype wire

// File: rtl/regfile_mp.sv
`default_nettype none
// ============================================================================
// regfile_mp : multi-port integer register file with write bypass and scoreboard
// Rev 1.0
// ============================================================================
module regfile_mp
    import regfile_pkg::*;
#(
    parameter  int XLEN  = XLEN_DEF,
    parameter  int NREGS = NREGS_DEF,
    parameter  int NRD   = 2,
    parameter  int NWR   = 2,
    localparam int AW    = $clog2(NREGS)
) (
    input  logic                clk,
    input  logic                reset,
    input  logic [NRD*AW-1:0]   rd_addr,
    output logic [NRD*XLEN-1:0] rd_data,
    output logic [NRD-1:0]      rd_busy,
    input  logic [NWR-1:0]      wr_en,
    input  logic [NWR*AW-1:0]   wr_addr,
    input  logic [NWR*XLEN-1:0] wr_data,
    input  logic                iss_en,
    input  logic [AW-1:0]       iss_addr,
    input  logic                flush
);

    logic [XLEN-1:0]  r_regs   [NREGS];
    logic [NREGS-1:0] w_wr_hit;
    logic [XLEN-1:0]  w_wr_val [NREGS];

    // Per-register write select; ascending scan lets the highest port win.
    always_comb begin
        w_wr_hit = '0;
        for (int r = 0; r < NREGS; r++) begin
            w_wr_val[r] = '0;
        end
        for (int j = 0; j < NWR; j++) begin
            if (wr_en[j]) begin
                w_wr_hit[wr_addr[j*AW +: AW]] = 1'b1;
                w_wr_val[wr_addr[j*AW +: AW]] = wr_data[j*XLEN +: XLEN];
            end
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            for (int r = 0; r < NREGS; r++) begin
                r_regs[r] <= '0;
            end
        end else begin
            for (int r = 1; r < NREGS; r++) begin
                if (w_wr_hit[r]) begin
                    r_regs[r] <= w_wr_val[r];
                end
            end
        end
    end

    for (genvar i = 0; i < NRD; i++) begin : g_rd
        logic [AW-1:0] w_addr;
        assign w_addr = rd_addr[i*AW +: AW];
        assign rd_data[i*XLEN +: XLEN] = (w_addr == '0)    ? '0 :
                                         w_wr_hit[w_addr] ? w_wr_val[w_addr] :
                                                            r_regs[w_addr];
    end

    regfile_scoreboard #(
        .NREGS (NREGS),
        .NRD   (NRD),
        .NWR   (NWR)
    ) u_scoreboard (
        .clk      (clk),
        .reset    (reset),
        .rd_addr  (rd_addr),
        .rd_busy  (rd_busy),
        .wr_en    (wr_en),
        .wr_addr  (wr_addr),
        .iss_en   (iss_en),
        .iss_addr (iss_addr),
        .flush    (flush)
    );

endmodule
`default_nettype wire
